cia_eclk_arbiter: RTL and testbench

Shares the E-clock-synchronous CIA register bus between two requesters: the 68k CPU bridge (port 0) and the host I/O controller (port 1). It runs on the 28 MHz clock and uses the 7 MHz clock enable and the decoded E-clock phase pulses `eclk[9:0]` from the clock generator. It grants at most one access per E period (10 E counts, 40 `clk_28` cycles) and drives VMA plus the address, data and write-enable on the CIA side. Each access completes with a one-cycle acknowledge and captured read data.

---
 rtl/cia_eclk_pkg.sv | 16 +
 rtl/eclk_rr_arb2.sv | 33 +++
 rtl/cia_eclk_arbiter.sv | 97 +++++++++
 tb/tb_cia_eclk_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cia_eclk_pkg.sv
// Shared types and constants for the E-clock-synchronous CIA bus arbiter.
package cia_eclk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam int ECLK_GRANT_SLOT = 3;
    localparam int ECLK_LATCH_SLOT = 9;

    localparam int PORT_CPU  = 0;
    localparam int PORT_HOST = 1;

endpackage

// File: rtl/eclk_rr_arb2.sv
// Two-request round-robin picker; the winner index is remembered on each grant strobe.
module eclk_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant_idx,
    output logic       grant_any
);

    // last = most recent winner; reset value 1 hands first priority to port 0
    logic last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (update && grant_any) begin
            last <= grant_idx;
        end
    end

    always_comb begin
        grant_any = |req;
        grant_idx = 1'b0;
        case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cia_eclk_arbiter.sv
// Shares the CIA register bus between the CPU bridge and the host I/O port,
// one access per E period, granted at E count 3 and completed at E count 9.
module cia_eclk_arbiter
    import cia_eclk_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic            clk_28,
    input  logic            rst_n,
    input  logic            clk7_en,
    input  logic [9:0]      eclk,
    input  logic [1:0]      req_valid,
    input  logic [1:0]      req_we,
    input  logic [2*AW-1:0] req_addr,
    input  logic [2*DW-1:0] req_wdata,
    output logic [1:0]      req_ack,
    output logic [DW-1:0]   req_rdata,
    output logic            cia_vma,
    output logic            cia_we,
    output logic [AW-1:0]   cia_addr,
    output logic [DW-1:0]   cia_wdata,
    input  logic [DW-1:0]   cia_rdata
);

    localparam logic [9:0] GRANT_MASK = 10'(1) << ECLK_GRANT_SLOT;
    localparam logic [9:0] LATCH_MASK = 10'(1) << ECLK_LATCH_SLOT;

    // Whole-vector compare: a slot fires only on a clean one-hot phase code.
    logic slot_grant;
    logic slot_latch;
    assign slot_grant = clk7_en && (eclk == GRANT_MASK);
    assign slot_latch = clk7_en && (eclk == LATCH_MASK);

    state_t state;
    state_t state_nx;
    logic   grant;
    logic   grant_idx;
    logic   grant_any;
    logic   owner;

    eclk_rr_arb2 u_arb (
        .clk       (clk_28),
        .rst_n     (rst_n),
        .req       (req_valid),
        .update    (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        case (state)
            IDLE: begin
                if (slot_grant && grant_any) begin
                    state_nx = ACCESS;
                    grant    = 1'b1;
                end
            end
            ACCESS: begin
                if (slot_latch) begin
                    state_nx = ACK;
                end
            end
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_28) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            cia_vma   <= 1'b0;
            cia_we    <= 1'b0;
            cia_addr  <= '0;
            cia_wdata <= '0;
            req_ack   <= '0;
            req_rdata <= '0;
        end else begin
            state   <= state_nx;
            cia_vma <= (state_nx == ACCESS);
            req_ack <= (state_nx == ACK) ? {owner, ~owner} : 2'b00;
            if (grant) begin
                owner     <= grant_idx;
                cia_we    <= grant_idx ? req_we[1] : req_we[0];
                cia_addr  <= grant_idx ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
                cia_wdata <= grant_idx ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
            end
            if (state == ACCESS && slot_latch && !cia_we) begin
                req_rdata <= cia_rdata;
            end
        end
    end

endmodule

// File: tb/tb_cia_eclk_arbiter.sv
// Directed bench for cia_eclk_arbiter: a table of single accesses plus
// hand-written arbitration, late-request, reset and drop sequences.
module tb_cia_eclk_arbiter;

    logic        clk_28;
    logic        rst_n;
    logic        clk7_en;
    logic [9:0]  eclk;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_ack;
    logic [7:0]  req_rdata;
    logic        cia_vma;
    logic        cia_we;
    logic [3:0]  cia_addr;
    logic [7:0]  cia_wdata;
    logic [7:0]  cia_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    cia_eclk_arbiter #(.AW(4), .DW(8)) dut (
        .clk_28    (clk_28),
        .rst_n     (rst_n),
        .clk7_en   (clk7_en),
        .eclk      (eclk),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ack   (req_ack),
        .req_rdata (req_rdata),
        .cia_vma   (cia_vma),
        .cia_we    (cia_we),
        .cia_addr  (cia_addr),
        .cia_wdata (cia_wdata),
        .cia_rdata (cia_rdata)
    );

    initial clk_28 = 1'b0;
    always #5 clk_28 = ~clk_28;

    // E-clock generator: 40 cycles per E period, clk7_en on every 4th cycle,
    // E count advances after each enabled edge. S(n) fires at cyc == 4n+3.
    initial begin
        clk7_en = (cyc % 4 == 3);
        eclk    = 10'd1 << (cyc / 4);
        forever begin
            @(posedge clk_28);
            #1;
            cyc     = (cyc + 1) % 40;
            clk7_en = (cyc % 4 == 3);
            eclk    = 10'd1 << (cyc / 4);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       port;
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] crd;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_28);
        #2;
    endtask

    // Returns when the next rising edge is the S(3) grant edge.
    task automatic wait_pre_grant();
        bit found = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (clk7_en && eclk[3]) begin
                found = 1;
                break;
            end
        end
        chk("pre_grant_timeout", found, 1);
    endtask

    task automatic wait_ack(output int p, output int cycles);
        p = -1;
        cycles = 0;
        for (int i = 1; i <= 130; i++) begin
            tick();
            if (req_ack != 2'b00) begin
                p = (req_ack == 2'b01) ? 0 : (req_ack == 2'b10) ? 1 : 2;
                cycles = i;
                break;
            end
        end
        if (p < 0) chk("ack_timeout", 0, 1);
    endtask

    task automatic set_port(input logic p, input logic we, input logic [3:0] a, input logic [7:0] d);
        if (p) begin
            req_we[1] = we; req_addr[7:4] = a; req_wdata[15:8] = d; req_valid[1] = 1'b1;
        end else begin
            req_we[0] = we; req_addr[3:0] = a; req_wdata[7:0] = d; req_valid[0] = 1'b1;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int errs = 0;
        int ack_at = 0;
        wait_pre_grant();
        req_valid = 2'b00;
        req_we    = {~v.we, ~v.we};
        req_addr  = {~v.addr, ~v.addr};
        req_wdata = {~v.wdata, ~v.wdata};
        set_port(v.port, v.we, v.addr, v.wdata);
        cia_rdata = v.crd;
        tick();
        chk($sformatf("v%0d_vma_rise", idx), cia_vma, 1);
        chk($sformatf("v%0d_addr", idx), cia_addr, v.addr);
        chk($sformatf("v%0d_we", idx), cia_we, v.we);
        chk($sformatf("v%0d_wdata", idx), cia_wdata, v.wdata);
        for (int i = 2; i <= 40; i++) begin
            tick();
            if (req_ack != 2'b00) begin
                ack_at = i;
                break;
            end
            if (!cia_vma || cia_we !== v.we || cia_addr !== v.addr || cia_wdata !== v.wdata) errs++;
        end
        chk($sformatf("v%0d_vma_hold", idx), errs, 0);
        chk($sformatf("v%0d_ack_latency", idx), ack_at, 25);
        chk($sformatf("v%0d_ack_port", idx), req_ack, v.port ? 2'b10 : 2'b01);
        chk($sformatf("v%0d_vma_fall", idx), cia_vma, 0);
        chk($sformatf("v%0d_rdata", idx), req_rdata, v.exp_rdata);
        req_valid = 2'b00;
        cia_rdata = 8'h00;
        tick();
        chk($sformatf("v%0d_ack_pulse", idx), req_ack, 0);
        chk($sformatf("v%0d_rdata_held", idx), req_rdata, v.exp_rdata);
    endtask

    initial begin
        int p;
        int cycles;
        int errs;
        int first_vma;

        vecs[0] = '{port: 1'b0, we: 1'b0, addr: 4'hA, wdata: 8'h12, crd: 8'h5C, exp_rdata: 8'h5C};
        vecs[1] = '{port: 1'b1, we: 1'b1, addr: 4'h3, wdata: 8'hA7, crd: 8'h11, exp_rdata: 8'h5C};
        vecs[2] = '{port: 1'b1, we: 1'b0, addr: 4'hF, wdata: 8'h00, crd: 8'hC3, exp_rdata: 8'hC3};
        vecs[3] = '{port: 1'b0, we: 1'b1, addr: 4'h0, wdata: 8'hFF, crd: 8'h00, exp_rdata: 8'hC3};
        vecs[4] = '{port: 1'b0, we: 1'b0, addr: 4'h5, wdata: 8'h66, crd: 8'h00, exp_rdata: 8'h00};
        vecs[5] = '{port: 1'b1, we: 1'b1, addr: 4'h9, wdata: 8'h3C, crd: 8'hEE, exp_rdata: 8'h00};

        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = 8'h00;
        req_wdata = 16'h0000;
        cia_rdata = 8'h00;
        repeat (3) tick();
        chk("rst_vma", cia_vma, 0);
        chk("rst_ack", req_ack, 0);
        chk("rst_rdata", req_rdata, 0);
        chk("rst_bus", {cia_we, cia_addr, cia_wdata}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Both valid from reset: port 0 first, port 1 exactly one E period later.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_we = 2'b00;
        req_addr = 8'h21;
        req_valid = 2'b11;
        wait_ack(p, cycles);
        chk("rr_first", p, 0);
        req_valid[0] = 1'b0;
        wait_ack(p, cycles);
        chk("rr_second", p, 1);
        chk("rr_second_gap", cycles, 40);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_ack(p, cycles);
            chk($sformatf("rr_alt%0d", i), p, i % 2);
        end
        req_valid = 2'b00;

        // Request raised one cycle after the S(3) edge waits a full period.
        wait_pre_grant();
        tick();
        set_port(1'b0, 1'b0, 4'h7, 8'h00);
        first_vma = 0;
        for (int i = 1; i <= 45; i++) begin
            tick();
            if (cia_vma) begin
                first_vma = i;
                break;
            end
        end
        chk("late_grant_delay", first_vma, 40);
        wait_ack(p, cycles);
        chk("late_ack_port", p, 0);
        req_valid = 2'b00;

        // Reset at E count 6 of a port 0 access; port 0 priority must return.
        wait_pre_grant();
        set_port(1'b0, 1'b1, 4'hC, 8'h5A);
        tick();
        chk("mid_vma_on", cia_vma, 1);
        for (int i = 0; i < 20; i++) begin
            if (eclk[6]) break;
            tick();
        end
        rst_n = 1'b0;
        req_valid = 2'b11;
        req_we = 2'b00;
        tick();
        rst_n = 1'b1;
        chk("mid_vma_off", cia_vma, 0);
        chk("mid_bus_clear", {cia_we, cia_addr, cia_wdata}, 0);
        errs = 0;
        for (int i = 0; i < 60; i++) begin
            if (clk7_en && eclk[3]) break;
            if (cia_vma || req_ack != 2'b00) errs++;
            tick();
        end
        chk("mid_no_ack", errs, 0);
        wait_ack(p, cycles);
        chk("mid_regrant_port0", p, 0);
        chk("mid_regrant_latency", cycles, 25);
        req_valid[0] = 1'b0;
        wait_ack(p, cycles);
        chk("mid_then_port1", p, 1);
        req_valid = 2'b00;

        // Port 1 drops valid right after its grant: still completes.
        wait_pre_grant();
        set_port(1'b1, 1'b0, 4'h4, 8'h00);
        cia_rdata = 8'h77;
        tick();
        req_valid = 2'b00;
        wait_ack(p, cycles);
        chk("drop_after_port", p, 1);
        chk("drop_after_rdata", req_rdata, 8'h77);

        // Port 1 drops valid before the grant edge: never served.
        tick();
        set_port(1'b1, 1'b0, 4'h8, 8'h00);
        wait_pre_grant();
        req_valid = 2'b00;
        errs = 0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (cia_vma || req_ack != 2'b00) errs++;
        end
        chk("drop_before_unserved", errs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
